pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register for the pipelined CPU. It replaces the fixed, always-loading inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, hazard stall, branch flush with bubble insertion, and an optional 2-entry skid buffer so that in_ready has no combinational path from out_ready.
- Sits between two adjacent stages. The payload is split into control bits (zeroed on bubbles) and data bits (held).

Parameters:
- DATA_W, 96, width of the data payload (rv1, rv2, imm, PC, idata, …), passed through unmodified.
- CTRL_W, 16, width of the control payload (regwrite, memwrite, branch, ALUop, …). Forced to 0 whenever the stage presents no valid beat.
- SKID, 0, 0 = single entry with pass-through ready; 1 = two entries with registered ready.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_W  upstream control payload
- in_data  in  DATA_W  upstream data payload
- stall  in  1  hazard-unit freeze
- flush  in  1  kill all held beats and the incoming beat
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control payload; 0 when out_valid=0
- out_data  out  DATA_W  data payload; holds last value when invalid
- occupancy  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1)
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n. Reset clears all entry valids, out_ctrl, out_data, occupancy and bubble_cnt to 0. Reset asserted mid-transfer drops the beat; there is no partial state.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready. Both may occur in the same cycle.
- Latency: 1 cycle from an input transfer to out_valid, for both SKID=0 and SKID=1, when the stage is empty.
- SKID=0:
  - One entry.
  - in_ready = !stall & (!full | out_ready).
  - out_valid = full & !stall.
- SKID=1:
  - Main entry plus skid entry. Output always comes from the main entry (FIFO order).
  - in_ready = !stall & !skid_full. This is a function of registered state and stall only.
  - An input arriving while main is full and not draining goes into skid.
  - When main drains, skid moves to main on the same edge.
  - A simultaneous drain and accept with skid empty loads main directly.
- stall=1:
  - in_ready=0 and out_valid=0, so out_ctrl=0.
  - All entries hold, and bubble_cnt increments.
  - The stall-to-output path is combinational.
- flush=1 (synchronous):
  - On the next edge all entries are invalidated and occupancy becomes 0.
  - An input beat transferred in the same cycle is discarded.
  - Flush has priority over stall. When both are asserted, the flush still clears the entries.
  - out_valid is unaffected in the flush cycle itself and is 0 from the next cycle.
  - in_ready ignores flush, so upstream can drain its wrong-path beat.
- Bubble masking: out_ctrl = main_ctrl when out_valid, else 0. This makes an invalid slot an architectural NOP (no regwrite, no memwrite, no branch).
- bubble_cnt: increments every cycle out_valid=0 and saturates at 2^CNT_W-1. Reset is the only way to clear it.
- Ordering: beats leave in arrival order. There is no duplication and no loss except by flush or reset.

Decomposition:
- Shared package/include pipe_pkg:
  - occupancy encodings: OCC_EMPTY, OCC_ONE, OCC_TWO
  - a NOP_CTRL constant of 0
  - standard widths for the CPU stages, e.g. ID_EX_CTRL_W and ID_EX_DATA_W
- Sub-module pipe_skid_buf: the two-entry storage and move logic, instantiated only under SKID=1 via generate.
- Stall and flush gating, ctrl masking and bubble_cnt stay in the top module.

Test Plan:
- Reset and fill (SKID=0):
  - Stimulus: release rst_n, drive in_valid=1, in_ctrl=0x0041, in_data=0x...00AB, out_ready=1.
  - Response: out_valid=1 the next cycle with out_ctrl=0x0041 and the same data. Before that edge, out_ctrl=0 and bubble_cnt=1.
- Backpressure (SKID=1):
  - Stimulus: hold out_ready=0 and send beats A=1, B=2, C=3.
  - Response: A and B are accepted and occupancy=2. in_ready drops while C is presented and C is held upstream.
  - Then raise out_ready: A, B, C leave on 3 consecutive cycles, in order.
- Stall:
  - Stimulus: with the stage full (ctrl 0x00FF), assert stall for 3 cycles.
  - Response: out_valid=0, out_ctrl=0, in_ready=0 and bubble_cnt +3. After release, the same beat 0x00FF appears with no loss.
- Flush with a simultaneous input:
  - Stimulus: occupancy=2 (SKID=1), then flush=1 together with in_valid=1 and ctrl 0x0005.
  - Response: next cycle occupancy=0 and out_valid=0. Beat 0x0005 never appears.
- Flush plus stall:
  - Stimulus: assert both flush and stall with occupancy=1.
  - Response: next cycle occupancy=0, and no beat is emitted after stall deasserts.
- Saturation and async reset:
  - Stimulus: CNT_W=4, idle 20 cycles.
  - Response: bubble_cnt=15 and holds. Pulse rst_n low mid-cycle and all outputs go to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU inter-stage registers: occupancy codes,
// the bubble control word and the standard ID/EX payload widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // All-zero control word: no regwrite, no memwrite, no branch.
    localparam logic [255:0] NOP_CTRL = '0;

    localparam int ID_EX_CTRL_W = 16;
    localparam int ID_EX_DATA_W = 96;

    function automatic occ_e occ_encode(input logic main_v, input logic skid_v);
        if (main_v && skid_v) begin
            return OCC_TWO;
        end else if (main_v || skid_v) begin
            return OCC_ONE;
        end
        return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry storage (main + skid) for the pipeline stage register.
// Output is always the main entry; the skid entry only ever holds the younger beat.
module pipe_skid_buf #(
    parameter int W = 112
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         main_valid,
    output logic         skid_valid,
    output logic [W-1:0] main_q
);

    logic [W-1:0] skid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                // Skid refills main; a same-cycle arrival takes the skid slot.
                main_q     <= skid_q;
                skid_valid <= push;
                if (push) begin
                    skid_q <= din;
                end
            end else begin
                main_valid <= push;
                if (push) begin
                    main_q <= din;
                end
            end
        end else if (push) begin
            if (main_valid) begin
                skid_valid <= 1'b1;
                skid_q     <= din;
            end else begin
                main_valid <= 1'b1;
                main_q     <= din;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready, hazard stall, branch flush,
// bubble masking of control bits and an optional two-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PW = CTRL_W + DATA_W;

    logic          main_valid;
    logic          skid_valid;
    logic [PW-1:0] main_q;
    logic          in_xfer;
    logic          out_xfer;
    logic          push;

    // Stall gates the output combinationally; flush only acts on the next edge.
    assign out_valid = main_valid & ~stall;
    assign out_xfer  = out_valid & out_ready;
    assign in_xfer   = in_valid & in_ready;
    assign push      = in_xfer & ~flush;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(
                .W(PW)
            ) u_skid_buf (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push),
                .pop       (out_xfer),
                .flush     (flush),
                .din       ({in_ctrl, in_data}),
                .main_valid(main_valid),
                .skid_valid(skid_valid),
                .main_q    (main_q)
            );
            // Registered state only: breaks the out_ready -> in_ready path.
            assign in_ready = ~stall & ~skid_valid;
        end else begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_q     <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (push) begin
                    main_valid <= 1'b1;
                    main_q     <= {in_ctrl, in_data};
                end else if (out_xfer) begin
                    main_valid <= 1'b0;
                end
            end
            assign skid_valid = 1'b0;
            assign in_ready   = ~stall & (~main_valid | out_ready);
        end
    endgenerate

    assign out_ctrl  = out_valid ? main_q[PW-1:DATA_W] : NOP_CTRL[CTRL_W-1:0];
    assign out_data  = main_q[DATA_W-1:0];
    assign occupancy = occ_encode(main_valid, skid_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 (4-bit bubble counter) and SKID=1 instances
// driven in parallel and compared every cycle against a queue-based model.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 16;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          stall;
    logic          flush;
    logic          out_ready;

    logic          in_ready0, in_ready1;
    logic          out_valid0, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    occ0, occ1;
    logic [3:0]    bcnt0;
    logic [15:0]   bcnt1;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0), .bubble_cnt(bcnt0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1), .bubble_cnt(bcnt1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each stage is a FIFO of capacity 1 or 2.
    beat_t       q[2][$];
    logic [DW-1:0] front_d[2];
    int unsigned bcnt_m[2];
    int unsigned cnt_max[2] = '{15, 65535};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic m_in_ready(input int s);
        if (stall) return 1'b0;
        if (s == 0) return (q[s].size() == 0) || out_ready;
        return q[s].size() < 2;
    endfunction

    function automatic logic m_out_valid(input int s);
        return (q[s].size() > 0) && !stall;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            q[s].delete();
            front_d[s] = '0;
            bcnt_m[s]  = 0;
        end
    endtask

    task automatic model_step(input int s);
        logic  ir;
        logic  ov;
        beat_t b;
        ir = m_in_ready(s);
        ov = m_out_valid(s);
        if (!ov && bcnt_m[s] < cnt_max[s]) bcnt_m[s]++;
        if (flush) begin
            q[s].delete();
        end else begin
            if (ov && out_ready) void'(q[s].pop_front());
            if (in_valid && ir) begin
                b.ctrl = in_ctrl;
                b.data = in_data;
                q[s].push_back(b);
            end
        end
        if (q[s].size() > 0) front_d[s] = q[s][0].data;
    endtask

    task automatic check_inst(input int s);
        logic          ir, ov, eov;
        logic [CW-1:0] oc, ectrl;
        logic [DW-1:0] od;
        logic [1:0]    oo;
        logic [15:0]   bc;
        if (s == 0) begin
            ir = in_ready0; ov = out_valid0; oc = out_ctrl0; od = out_data0; oo = occ0; bc = {12'd0, bcnt0};
        end else begin
            ir = in_ready1; ov = out_valid1; oc = out_ctrl1; od = out_data1; oo = occ1; bc = bcnt1;
        end
        eov   = m_out_valid(s);
        ectrl = '0;
        if (eov) ectrl = q[s][0].ctrl;
        chk($sformatf("u%0d_in_ready", s), ir, m_in_ready(s));
        chk($sformatf("u%0d_out_valid", s), ov, eov);
        chk($sformatf("u%0d_out_ctrl", s), oc, ectrl);
        chk($sformatf("u%0d_out_data", s), od, front_d[s]);
        chk($sformatf("u%0d_occupancy", s), oo, q[s].size());
        chk($sformatf("u%0d_bubble_cnt", s), bc, bcnt_m[s]);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    logic [15:0] bsave;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Reset and fill
        in_valid = 1'b1; in_ctrl = 16'h0041; in_data = 96'hAB; out_ready = 1'b1;
        #1;
        chk("fill_pre_ctrl", out_ctrl0, 16'h0);
        chk("fill_pre_bcnt", bcnt0, 4'd1);
        cycle();
        in_valid = 1'b0;
        #1;
        chk("fill_valid", out_valid0, 1'b1);
        chk("fill_ctrl", out_ctrl0, 16'h0041);
        chk("fill_data", out_data0, 96'hAB);
        chk("fill_ctrl_skid", out_ctrl1, 16'h0041);
        cycle();

        // Backpressure on the skid stage
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'd1; in_data = rand_data();
        cycle();
        in_ctrl = 16'd2; in_data = rand_data();
        cycle();
        in_ctrl = 16'd3; in_data = rand_data();
        #1;
        chk("bp_occ2", occ1, 2'd2);
        chk("bp_c_held", in_ready1, 1'b0);
        cycle();
        out_ready = 1'b1;
        #1;
        chk("bp_out_a", out_ctrl1, 16'd1);
        cycle();
        chk("bp_out_b", out_ctrl1, 16'd2);
        cycle();
        in_valid = 1'b0;
        #1;
        chk("bp_out_c", out_ctrl1, 16'd3);
        cycle();

        // Stall with a full stage
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00FF; in_data = rand_data();
        cycle();
        in_valid = 1'b0; stall = 1'b1;
        #1;
        bsave = bcnt1;
        chk("stall_out_valid", out_valid1, 1'b0);
        chk("stall_out_ctrl", out_ctrl1, 16'h0);
        chk("stall_in_ready", in_ready1, 1'b0);
        cycle(); cycle(); cycle();
        stall = 1'b0;
        #1;
        chk("stall_bcnt", bcnt1, bsave + 16'd3);
        chk("stall_resume", out_ctrl1, 16'h00FF);
        out_ready = 1'b1;
        cycle();

        // Flush with a simultaneous input beat
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h000A; in_data = rand_data();
        cycle();
        in_ctrl = 16'h000B; in_data = rand_data();
        cycle();
        chk("flush_occ2", occ1, 2'd2);
        flush = 1'b1; out_ready = 1'b1; in_ctrl = 16'h0005; in_data = rand_data();
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_occ0", occ1, 2'd0);
        chk("flush_out_valid", out_valid1, 1'b0);
        chk("flush_occ0_single", occ0, 2'd0);
        repeat (3) cycle();

        // Flush together with stall
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0077; in_data = rand_data();
        cycle();
        in_valid = 1'b0;
        #1;
        chk("fs_occ1", occ1, 2'd1);
        flush = 1'b1; stall = 1'b1;
        cycle();
        flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
        #1;
        chk("fs_occ0", occ1, 2'd0);
        chk("fs_no_beat", out_valid1, 1'b0);
        repeat (2) cycle();

        // Bubble counter saturation, then asynchronous reset mid-cycle
        repeat (20) cycle();
        chk("sat_bcnt", bcnt0, 4'd15);
        cycle();
        chk("sat_hold", bcnt0, 4'd15);
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h1234; in_data = rand_data();
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov0", out_valid0, 1'b0);
        chk("arst_ctrl0", out_ctrl0, 16'h0);
        chk("arst_data0", out_data0, 96'h0);
        chk("arst_occ0", occ0, 2'd0);
        chk("arst_bcnt0", bcnt0, 4'd0);
        chk("arst_ov1", out_valid1, 1'b0);
        chk("arst_ctrl1", out_ctrl1, 16'h0);
        chk("arst_data1", out_data1, 96'h0);
        chk("arst_occ1", occ1, 2'd0);
        chk("arst_bcnt1", bcnt1, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_ctrl   = 16'($urandom());
            in_data   = rand_data();
            out_ready = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
